// File: rtl/rr_pop_sched_if.sv
// Bus between the round-robin dequeue stage, the shared multi-queue buffer and the consumer.
// The scheduler takes the master side; the environment takes the slave side.
interface rr_pop_sched_if #(
    parameter int BITDATA = 4,
    parameter int NUMFIFO = 8
);
    localparam int BITFIFO = $clog2(NUMFIFO);

    logic               push;
    logic [BITFIFO-1:0] pu_prt;
    logic               pop;
    logic [BITFIFO-1:0] po_prt;
    logic [BITDATA-1:0] po_dout;
    logic               out_vld;
    logic               out_rdy;
    logic [BITFIFO-1:0] out_prt;
    logic [BITDATA-1:0] out_data;
    logic [NUMFIFO-1:0] q_full;
    logic [NUMFIFO-1:0] q_empty;
    logic               ovf_err;

    modport master (
        input  push, pu_prt, po_dout, out_rdy,
        output pop, po_prt, out_vld, out_prt, out_data, q_full, q_empty, ovf_err
    );

    modport slave (
        output push, pu_prt, po_dout, out_rdy,
        input  pop, po_prt, out_vld, out_prt, out_data, q_full, q_empty, ovf_err
    );
endinterface

// File: rtl/rr_pop_sched.sv
// Round-robin dequeue stage: tracks per-queue occupancy by snooping pushes, pops one
// non-empty queue per cycle and holds the result in a registered valid/ready stage.
module rr_pop_sched #(
    parameter int NUMELEM = 4,
    parameter int BITDATA = 4,
    parameter int NUMFIFO = 8
) (
    input  logic           clk,
    input  logic           rst,
    rr_pop_sched_if.master bus
);
    localparam int BITELEM = $clog2(NUMELEM);
    localparam int BITFIFO = $clog2(NUMFIFO);
    localparam logic [BITELEM:0]   FULL_CNT = NUMELEM[BITELEM:0];
    localparam logic [BITFIFO-1:0] LAST_IDX = BITFIFO'(NUMFIFO - 1);

    logic [BITELEM:0]   cnt_q [NUMFIFO];
    logic [BITELEM:0]   cnt_d [NUMFIFO];
    logic [NUMFIFO-1:0] elig;
    logic [NUMFIFO-1:0] push_hit;
    logic [NUMFIFO-1:0] pop_hit;
    logic [BITFIFO-1:0] last_grant_q, last_grant_d;
    logic [BITFIFO-1:0] sel, sel_hi, sel_lo;
    logic               found_hi, found_lo;
    logic               pop;
    logic               push_oob;
    logic               ovf_hit;
    logic               out_vld_q, out_vld_d;
    logic [BITFIFO-1:0] out_prt_q, out_prt_d;
    logic [BITDATA-1:0] out_data_q, out_data_d;
    logic               ovf_q, ovf_d;

    always_comb begin
        for (int i = 0; i < NUMFIFO; i++) begin
            elig[i]        = (cnt_q[i] != '0);
            bus.q_empty[i] = (cnt_q[i] == '0);
            bus.q_full[i]  = (cnt_q[i] == FULL_CNT);
        end
    end

    // Lowest eligible index above last_grant wins; otherwise wrap to the lowest eligible index.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        found_hi = 1'b0;
        found_lo = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int i = 0; i < NUMFIFO; i++) begin
            if (elig[i] && !found_lo) begin
                found_lo = 1'b1;
                sel_lo   = BITFIFO'(i);
            end
            if (elig[i] && !found_hi && (BITFIFO'(i) > last_grant_q)) begin
                found_hi = 1'b1;
                sel_hi   = BITFIFO'(i);
            end
        end
        sel = found_hi ? sel_hi : sel_lo;
    end

    assign pop        = !rst && (|elig) && (!out_vld_q || bus.out_rdy);
    assign bus.pop    = pop;
    assign bus.po_prt = pop ? sel : '0;

    if (NUMFIFO == (1 << BITFIFO)) begin : g_pow2
        assign push_oob = 1'b0;
    end else begin : g_npow2
        assign push_oob = bus.push && (int'(bus.pu_prt) >= NUMFIFO);
    end

    // A push into a full queue is dropped unless the same queue is popped in that cycle.
    always_comb begin
        ovf_hit = push_oob;
        for (int i = 0; i < NUMFIFO; i++) begin
            push_hit[i] = bus.push && (bus.pu_prt == BITFIFO'(i));
            pop_hit[i]  = pop && (sel == BITFIFO'(i));
            cnt_d[i]    = cnt_q[i];
            if (push_hit[i] && !pop_hit[i]) begin
                if (cnt_q[i] == FULL_CNT) ovf_hit = 1'b1;
                else                      cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (pop_hit[i] && !push_hit[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        out_vld_d    = out_vld_q;
        out_prt_d    = out_prt_q;
        out_data_d   = out_data_q;
        last_grant_d = last_grant_q;
        ovf_d        = ovf_q | ovf_hit;
        if (pop) begin
            out_vld_d    = 1'b1;
            out_prt_d    = sel;
            out_data_d   = bus.po_dout;
            last_grant_d = sel;
        end else if (bus.out_rdy) begin
            out_vld_d = 1'b0;
        end
    end

    // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the count array is control state, not bulk data, so it must be reset.
            for (int i = 0; i < NUMFIFO; i++) cnt_q[i] <= '0;
            last_grant_q <= LAST_IDX;
            out_vld_q    <= 1'b0;
            out_prt_q    <= '0;
            out_data_q   <= '0;
            ovf_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            out_vld_q    <= out_vld_d;
            out_prt_q    <= out_prt_d;
            out_data_q   <= out_data_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.out_vld  = out_vld_q;
    assign bus.out_prt  = out_prt_q;
    assign bus.out_data = out_data_q;
    assign bus.ovf_err  = ovf_q;
endmodule

// File: tb/tb_rr_pop_sched.sv
// Bench for rr_pop_sched: a queue-based model of the shared buffer and of the scheduling
// rules supplies po_dout and the expected pop, grant and output-stage values.
module tb_rr_pop_sched;
    localparam int NUMELEM = 4;
    localparam int BITDATA = 4;
    localparam int NUMFIFO = 8;
    localparam int BITFIFO = $clog2(NUMFIFO);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_pop_sched_if #(.BITDATA(BITDATA), .NUMFIFO(NUMFIFO)) bus ();

    rr_pop_sched #(.NUMELEM(NUMELEM), .BITDATA(BITDATA), .NUMFIFO(NUMFIFO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: buffer contents per queue, output stage, priority pointer and sticky error.
    logic [BITDATA-1:0] bq [NUMFIFO][$];
    int                 m_last;
    logic               m_vld;
    logic [BITFIFO-1:0] m_prt;
    logic [BITDATA-1:0] m_data;
    logic               m_ovf;

    logic               obs_pop;
    logic [BITFIFO-1:0] obs_prt;
    logic               exp_pop;
    logic [BITFIFO-1:0] exp_prt;
    int                 exp_sel;
    int                 total = 0;
    int                 bad   = 0;

    function automatic int model_sel();
        for (int k = 1; k <= NUMFIFO; k++) begin
            int idx;
            idx = (m_last + k) % NUMFIFO;
            if (bq[idx].size() > 0) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NUMFIFO-1:0] m_full();
        logic [NUMFIFO-1:0] v;
        for (int i = 0; i < NUMFIFO; i++) v[i] = (bq[i].size() == NUMELEM);
        return v;
    endfunction

    function automatic logic [NUMFIFO-1:0] m_empty();
        logic [NUMFIFO-1:0] v;
        for (int i = 0; i < NUMFIFO; i++) v[i] = (bq[i].size() == 0);
        return v;
    endfunction

    // One clock cycle: drive inputs after the falling edge, act as the buffer, update the model.
    task automatic step(input logic p, input int prt, input logic [BITDATA-1:0] d,
                        input logic rdy, input logic r);
        rst         = r;
        bus.push    = p;
        bus.pu_prt  = BITFIFO'(prt);
        bus.out_rdy = rdy;
        exp_sel     = model_sel();
        exp_pop     = !r && (exp_sel >= 0) && (!m_vld || rdy);
        exp_prt     = exp_pop ? BITFIFO'(exp_sel) : '0;
        #1;
        obs_pop     = bus.pop;
        obs_prt     = bus.po_prt;
        bus.po_dout = exp_pop ? bq[exp_sel][0] : BITDATA'($urandom);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < NUMFIFO; i++) bq[i].delete();
            m_last = NUMFIFO - 1;
            m_vld  = 1'b0;
            m_prt  = '0;
            m_data = '0;
            m_ovf  = 1'b0;
        end else begin
            if (exp_pop) begin
                m_data = bq[exp_sel].pop_front();
                m_prt  = BITFIFO'(exp_sel);
                m_vld  = 1'b1;
                m_last = exp_sel;
            end else if (rdy) begin
                m_vld = 1'b0;
            end
            if (p) begin
                if (prt >= NUMFIFO || bq[prt].size() >= NUMELEM) m_ovf = 1'b1;
                else bq[prt].push_back(d);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1'b0, 0, '0, 1'b1, 1'b1);
        step(1'b0, 0, '0, 1'b1, 1'b1);
        total++; if (obs_pop !== 1'b0) begin bad++; $display("FAIL reset_pop got=%0b exp=0", obs_pop); end
        total++; if (bus.out_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%0b exp=0", bus.out_vld); end
        total++; if (bus.out_data !== '0 || bus.out_prt !== '0) begin bad++; $display("FAIL reset_out got=%0h/%0d exp=0/0", bus.out_data, bus.out_prt); end
        total++; if (bus.q_empty !== '1 || bus.q_full !== '0) begin bad++; $display("FAIL reset_flags got=%b/%b exp=all1/all0", bus.q_empty, bus.q_full); end
        total++; if (bus.ovf_err !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", bus.ovf_err); end
    endtask

    task automatic test_single_queue();
        step(1'b1, 2, 4'd1, 1'b1, 1'b0);
        total++; if (obs_pop !== 1'b0) begin bad++; $display("FAIL sq_first_pop got=%0b exp=0", obs_pop); end
        step(1'b1, 2, 4'd2, 1'b1, 1'b0);
        total++; if (obs_pop !== 1'b1 || obs_prt !== 3'd2) begin bad++; $display("FAIL sq_pop got=%0b/%0d exp=1/2", obs_pop, obs_prt); end
        total++; if (bus.out_vld !== 1'b1 || bus.out_data !== 4'd1 || bus.out_prt !== 3'd2) begin bad++; $display("FAIL sq_out1 got=%0b/%0d/%0d exp=1/1/2", bus.out_vld, bus.out_data, bus.out_prt); end
        step(1'b1, 2, 4'd3, 1'b1, 1'b0);
        total++; if (bus.out_data !== 4'd2 || bus.out_prt !== 3'd2) begin bad++; $display("FAIL sq_out2 got=%0d/%0d exp=2/2", bus.out_data, bus.out_prt); end
        step(1'b0, 0, '0, 1'b1, 1'b0);
        total++; if (bus.out_vld !== 1'b1 || bus.out_data !== 4'd3) begin bad++; $display("FAIL sq_out3 got=%0b/%0d exp=1/3", bus.out_vld, bus.out_data); end
        total++; if (bus.q_empty[2] !== 1'b1) begin bad++; $display("FAIL sq_empty got=%0b exp=1", bus.q_empty[2]); end
        step(1'b0, 0, '0, 1'b1, 1'b0);
        total++; if (bus.out_vld !== 1'b0 || obs_pop !== 1'b0) begin bad++; $display("FAIL sq_drain got=%0b/%0b exp=0/0", bus.out_vld, obs_pop); end
    endtask

    task automatic test_round_robin();
        int fill_q [6] = '{0, 0, 3, 3, 7, 7};
        int want   [6] = '{0, 3, 7, 0, 3, 7};
        int grants [$];
        step(1'b0, 0, '0, 1'b1, 1'b1);
        foreach (fill_q[i]) begin
            step(1'b1, fill_q[i], BITDATA'(i), 1'b0, 1'b0);
            if (obs_pop === 1'b1) grants.push_back(int'(obs_prt));
        end
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 0, '0, 1'b1, 1'b0);
            if (obs_pop === 1'b1) grants.push_back(int'(obs_prt));
        end
        total++; if (grants.size() != 6) begin bad++; $display("FAIL rr_count got=%0d exp=6", grants.size()); end
        for (int i = 0; i < 6 && i < grants.size(); i++) begin
            total++; if (grants[i] != want[i]) begin bad++; $display("FAIL rr_grant%0d got=%0d exp=%0d", i, grants[i], want[i]); end
        end
        total++; if (bus.q_empty !== '1) begin bad++; $display("FAIL rr_empty got=%b exp=all1", bus.q_empty); end
    endtask

    task automatic test_stall();
        int pops = 0;
        step(1'b0, 0, '0, 1'b1, 1'b1);
        step(1'b1, 1, 4'd9,  1'b0, 1'b0); pops += int'(obs_pop);
        step(1'b1, 4, 4'd5,  1'b0, 1'b0); pops += int'(obs_pop);
        step(1'b1, 4, 4'd6,  1'b0, 1'b0); pops += int'(obs_pop);
        step(1'b1, 1, 4'd10, 1'b0, 1'b0); pops += int'(obs_pop);
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 0, '0, 1'b0, 1'b0);
            pops += int'(obs_pop);
            total++; if (bus.out_vld !== 1'b1 || bus.out_data !== 4'd9 || bus.out_prt !== 3'd1) begin bad++; $display("FAIL stall_hold c=%0d got=%0b/%0d/%0d exp=1/9/1", c, bus.out_vld, bus.out_data, bus.out_prt); end
        end
        total++; if (pops != 1) begin bad++; $display("FAIL stall_pops got=%0d exp=1", pops); end
        step(1'b0, 0, '0, 1'b1, 1'b0);
        total++; if (obs_pop !== 1'b1 || obs_prt !== 3'd4) begin bad++; $display("FAIL stall_resume got=%0b/%0d exp=1/4", obs_pop, obs_prt); end
        total++; if (bus.out_data !== 4'd5 || bus.out_prt !== 3'd4) begin bad++; $display("FAIL stall_next got=%0d/%0d exp=5/4", bus.out_data, bus.out_prt); end
    endtask

    task automatic test_overflow();
        step(1'b0, 0, '0, 1'b1, 1'b1);
        step(1'b1, 6, 4'd2, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, 5, BITDATA'(k + 3), 1'b0, 1'b0);
        total++; if (bus.q_full[5] !== 1'b1 || bus.ovf_err !== 1'b0) begin bad++; $display("FAIL ovf_fill got=%0b/%0b exp=1/0", bus.q_full[5], bus.ovf_err); end
        step(1'b1, 5, 4'd12, 1'b1, 1'b0);
        total++; if (obs_pop !== 1'b1 || obs_prt !== 3'd5) begin bad++; $display("FAIL ovf_pushpop got=%0b/%0d exp=1/5", obs_pop, obs_prt); end
        total++; if (bus.ovf_err !== 1'b0 || bus.q_full[5] !== 1'b1) begin bad++; $display("FAIL ovf_net got=%0b/%0b exp=0/1", bus.ovf_err, bus.q_full[5]); end
        step(1'b1, 5, 4'd13, 1'b0, 1'b0);
        total++; if (bus.ovf_err !== 1'b1 || bus.q_full[5] !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b/%0b exp=1/1", bus.ovf_err, bus.q_full[5]); end
        step(1'b0, 0, '0, 1'b0, 1'b0);
        step(1'b0, 0, '0, 1'b0, 1'b0);
        total++; if (bus.ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b exp=1", bus.ovf_err); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 3, 4'd7, 1'b1, 1'b1);
        total++; if (obs_pop !== 1'b0) begin bad++; $display("FAIL rmid_pop got=%0b exp=0", obs_pop); end
        total++; if (bus.out_vld !== 1'b0 || bus.ovf_err !== 1'b0) begin bad++; $display("FAIL rmid_out got=%0b/%0b exp=0/0", bus.out_vld, bus.ovf_err); end
        total++; if (bus.q_empty !== '1 || bus.q_full !== '0) begin bad++; $display("FAIL rmid_flags got=%b/%b exp=all1/all0", bus.q_empty, bus.q_full); end
        step(1'b1, 0, 4'd11, 1'b1, 1'b0);
        step(1'b0, 0, '0, 1'b1, 1'b0);
        total++; if (obs_pop !== 1'b1 || obs_prt !== 3'd0) begin bad++; $display("FAIL rmid_grant got=%0b/%0d exp=1/0", obs_pop, obs_prt); end
    endtask

    task automatic test_empty_push();
        step(1'b0, 0, '0, 1'b1, 1'b1);
        step(1'b1, 1, 4'd4, 1'b1, 1'b0);
        total++; if (obs_pop !== 1'b0) begin bad++; $display("FAIL ep_same got=%0b exp=0", obs_pop); end
        step(1'b0, 0, '0, 1'b1, 1'b0);
        total++; if (obs_pop !== 1'b1 || obs_prt !== 3'd1) begin bad++; $display("FAIL ep_next got=%0b/%0d exp=1/1", obs_pop, obs_prt); end
    endtask

    task automatic test_random();
        step(1'b0, 0, '0, 1'b1, 1'b1);
        for (int c = 0; c < 400; c++) begin
            step(logic'($urandom_range(9) < 6), int'($urandom_range(NUMFIFO - 1)),
                 BITDATA'($urandom), logic'($urandom_range(9) < 7), logic'($urandom_range(99) == 0));
            total++; if (obs_pop !== exp_pop || obs_prt !== exp_prt) begin bad++; $display("FAIL rand_pop c=%0d got=%0b/%0d exp=%0b/%0d", c, obs_pop, obs_prt, exp_pop, exp_prt); end
            total++; if (bus.out_vld !== m_vld) begin bad++; $display("FAIL rand_vld c=%0d got=%0b exp=%0b", c, bus.out_vld, m_vld); end
            total++; if (bus.out_prt !== m_prt || bus.out_data !== m_data) begin bad++; $display("FAIL rand_out c=%0d got=%0d/%0h exp=%0d/%0h", c, bus.out_prt, bus.out_data, m_prt, m_data); end
            total++; if (bus.q_full !== m_full() || bus.q_empty !== m_empty()) begin bad++; $display("FAIL rand_flags c=%0d got=%b/%b exp=%b/%b", c, bus.q_full, bus.q_empty, m_full(), m_empty()); end
            total++; if (bus.ovf_err !== m_ovf) begin bad++; $display("FAIL rand_ovf c=%0d got=%0b exp=%0b", c, bus.ovf_err, m_ovf); end
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.push    = 1'b0;
        bus.pu_prt  = '0;
        bus.out_rdy = 1'b1;
        bus.po_dout = '0;
        m_last      = NUMFIFO - 1;
        m_vld       = 1'b0;
        m_prt       = '0;
        m_data      = '0;
        m_ovf       = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_queue();
        test_round_robin();
        test_stall();
        test_overflow();
        test_reset_mid();
        test_empty_push();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
